inst_fetch_resp: RTL

- Memory-side responder for the fetch stage's pc/ce pair.
- Accepts one fetch address at a time and translates kseg0/kseg1 addresses to physical addresses.
- Issues the fetch on an SRAM-like instruction bus (req/addr_ok/data_ok), captures the returned word and presents it to the decode stage.
- Asserts stallreq to the pipeline controller while a fetch is outstanding, so the PC holds until its instruction is returned.

---
 rtl/inst_fetch_resp.sv | 137 +++++++++++++
 1 files changed

// File: rtl/inst_fetch_resp.sv
// Fetch responder: translates pc, runs one SRAM-like instruction read at a time and hands the word to decode.
// Latency is 3 cycles from pc to inst_valid at best. stallreq holds the PC while a fetch is open; stall_id freezes the captured word in HOLD.
module inst_fetch_resp #(
  parameter bit          ADDR_MAP_EN = 1'b1,
  parameter logic [31:0] NOP_INST    = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce,
  input  logic [31:0] pc,
  input  logic        stall_id,
  input  logic        flush,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  input  logic [31:0] inst_rdata,
  output logic [31:0] inst,
  output logic        inst_valid,
  output logic        adel,
  output logic        stallreq
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;

  state_t      state, state_nxt;
  logic        discard, discard_nxt;
  logic        inst_req_nxt;
  logic [31:0] inst_addr_nxt;
  logic [31:0] inst_nxt;
  logic        inst_valid_nxt;
  logic        adel_nxt;
  logic        complete;
  logic        pc_aligned;
  logic [31:0] pc_phys;

  assign pc_aligned = (pc[1:0] == 2'b00);

  // kseg0/kseg1 both map onto the low 512 MB of physical space.
  always_comb begin
    pc_phys = pc;
    if (ADDR_MAP_EN && ((pc[31:29] == 3'b100) || (pc[31:29] == 3'b101))) begin
      pc_phys = {3'b000, pc[28:0]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      discard    <= 1'b0;
      inst_req   <= 1'b0;
      inst_addr  <= 32'h0000_0000;
      inst       <= NOP_INST;
      inst_valid <= 1'b0;
      adel       <= 1'b0;
    end else begin
      state      <= state_nxt;
      discard    <= discard_nxt;
      inst_req   <= inst_req_nxt;
      inst_addr  <= inst_addr_nxt;
      inst       <= inst_nxt;
      inst_valid <= inst_valid_nxt;
      adel       <= adel_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    discard_nxt    = discard;
    inst_req_nxt   = inst_req;
    inst_addr_nxt  = inst_addr;
    inst_nxt       = inst;
    inst_valid_nxt = inst_valid;
    adel_nxt       = adel;
    complete       = 1'b0;

    case (state)
      IDLE: begin
        inst_valid_nxt = 1'b0;
        inst_nxt       = NOP_INST;
        adel_nxt       = 1'b0;
        if (ce && !flush && !discard) begin
          if (pc_aligned) begin
            inst_req_nxt  = 1'b1;
            inst_addr_nxt = pc_phys;
            state_nxt     = REQ;
          end else begin
            inst_valid_nxt = 1'b1;
            adel_nxt       = 1'b1;
            if (stall_id) state_nxt = HOLD;
          end
        end
      end
      REQ: begin
        // The request stays up through a flush; the returning word is dropped instead.
        if (flush) discard_nxt = 1'b1;
        if (inst_addr_ok) begin
          inst_req_nxt = 1'b0;
          state_nxt    = WAIT;
          complete     = inst_data_ok;
        end
      end
      WAIT: begin
        if (flush) discard_nxt = 1'b1;
        complete = inst_data_ok;
      end
      HOLD: begin
        if (flush || !stall_id) begin
          inst_valid_nxt = 1'b0;
          inst_nxt       = NOP_INST;
          adel_nxt       = 1'b0;
          state_nxt      = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase

    if (complete) begin
      discard_nxt = 1'b0;
      if (discard || flush) begin
        state_nxt = IDLE;
      end else begin
        inst_nxt       = inst_rdata;
        inst_valid_nxt = 1'b1;
        adel_nxt       = 1'b0;
        state_nxt      = stall_id ? HOLD : IDLE;
      end
    end
  end

  // Released in the data_ok cycle so the PC advances on the same edge that captures inst.
  assign stallreq = !rst && ce && !flush &&
                    (((state == IDLE) && pc_aligned && !discard) ||
                     (state == REQ) ||
                     ((state == WAIT) && !(inst_data_ok && !discard)));

endmodule
